bnn_tray_scheduler: RTL

BNN_TRAY_SCHEDULER -- requirements
Module: bnn_tray_scheduler

---
 rtl/bnn_sched_pkg.sv | 12 +
 rtl/rr_arbiter4.sv | 23 ++
 rtl/bnn_tray_scheduler.sv | 92 +++++++++
 3 files changed

// File: rtl/bnn_sched_pkg.sv
// bnn_sched_pkg: shared sizes and FSM state type for the BNN tray scheduler
package bnn_sched_pkg;
    localparam int NUM_TRAYS = 4;
    localparam int FEAT_W    = 16;
    localparam int CLASS_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin pick starting one above the last granted tray
module rr_arbiter4
    import bnn_sched_pkg::*;
(
    input  logic [NUM_TRAYS-1:0] elig,
    input  logic [1:0]           ptr,
    output logic [NUM_TRAYS-1:0] grant,
    output logic                 any
);
    logic [1:0] idx;

    // scan from farthest to nearest so the tray closest above ptr wins
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_TRAYS; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (elig[idx]) grant = 4'b0001 << idx;
        end
    end

    assign any = |elig;
endmodule

// File: rtl/bnn_tray_scheduler.sv
// bnn_tray_scheduler: shares one BNN core among four trays and collects per-tray results
module bnn_tray_scheduler
    import bnn_sched_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic [NUM_TRAYS-1:0]           req,
    input  logic [NUM_TRAYS*FEAT_W-1:0]    feat_i,
    output logic [NUM_TRAYS-1:0]           gnt,
    output logic                           core_start,
    output logic [FEAT_W-1:0]              core_feat,
    input  logic                           core_done,
    input  logic [CLASS_W-1:0]             core_class,
    output logic [NUM_TRAYS-1:0]           res_valid,
    input  logic [NUM_TRAYS-1:0]           res_ack,
    output logic [NUM_TRAYS*CLASS_W-1:0]   res_class,
    output logic                           busy,
    output logic                           timeout_err
);
    state_t                state, state_n;
    logic [1:0]            ptr, sel, gsel;
    logic [3:0]            timer;
    logic [NUM_TRAYS-1:0]  elig, arb_gnt, set_mask, gnt_r;
    logic                  arb_any, start_r;

    assign elig       = req & ~res_valid;
    assign set_mask   = (state == ST_WAIT && core_done) ? 4'b0001 << sel : 4'b0000;
    assign gnt        = gnt_r & {NUM_TRAYS{ena}};
    assign core_start = start_r & ena;

    rr_arbiter4 u_arb (
        .elig  (elig),
        .ptr   (ptr),
        .grant (arb_gnt),
        .any   (arb_any)
    );

    // one-hot grant to tray index
    always_comb begin
        gsel = arb_gnt[1] ? 2'd1 : arb_gnt[2] ? 2'd2 : arb_gnt[3] ? 2'd3 : 2'd0;
    end

    // next state: a done or the last timer tick both end the wait
    always_comb begin
        state_n = !ena                ? state :
                  state == ST_IDLE    ? (arb_any ? ST_ISSUE : ST_IDLE) :
                  state == ST_ISSUE   ? ST_WAIT :
                  (core_done || timer == 4'd1) ? ST_IDLE : ST_WAIT;
    end

    // all scheduler state; ena low freezes everything including ack handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= 2'd3;
            sel         <= 2'd0;
            timer       <= 4'd0;
            gnt_r       <= '0;
            start_r     <= 1'b0;
            core_feat   <= '0;
            res_valid   <= '0;
            res_class   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else if (ena) begin
            state   <= state_n;
            busy    <= state_n != ST_IDLE;
            gnt_r   <= '0;
            start_r <= 1'b0;
            if (state == ST_IDLE && arb_any) begin
                gnt_r     <= arb_gnt;
                start_r   <= 1'b1;
                sel       <= gsel;
                ptr       <= gsel;
                core_feat <= feat_i[{gsel, 4'b0000} +: FEAT_W];
            end
            if (state == ST_ISSUE) timer <= 4'(TIMEOUT);
            if (state == ST_WAIT) begin
                if (core_done) begin
                    res_class[int'(sel)*CLASS_W +: CLASS_W] <= core_class;
                end else begin
                    timer <= timer - 4'd1;
                    if (timer == 4'd1) timeout_err <= 1'b1;
                end
            end
            res_valid <= (res_valid | set_mask) & ~res_ack;
        end
    end
endmodule
